// File: rtl/ex_if.sv
// ---------------------------------------------------------------------------
// ex_if
// Bundles the signals between the ID/EX register and the execute stage.
//
// Decoded operation (driven by the ID/EX side, the "master"):
//   aluop_i [7:0]    operation subtype
//   alusel_i [2:0]   result class
//   reg1_i [31:0]    operand 1 / shift amount
//   reg2_i [31:0]    operand 2 or immediate / shift value
//   wd_i [4:0]       destination register address
//   wreg_i           destination write enable
//   flush_i          abort of an in-flight division
// Results (driven by the execute stage, the "slave"):
//   wd_o, wreg_o, wdata_o      register-file write for EX/MEM and forwarding
//   whilo_o, hi_o, lo_o        HI/LO write-back from the divider
//   stallreq_o                 stall request to the pipeline controller
// ---------------------------------------------------------------------------
interface ex_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic        flush_i;

    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        stallreq_o;

    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        input  wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );

    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, wd_i, wreg_i, flush_i,
        output wd_o, wreg_o, wdata_o, whilo_o, hi_o, lo_o, stallreq_o
    );
endinterface

// File: rtl/ex.sv
// ---------------------------------------------------------------------------
// ex
// Execute stage of the five-stage pipeline. Computes the logic, shift and
// arithmetic results combinationally from the decoded operation, and runs an
// iterative restoring divider (signed DIV / unsigned DIVU) whose quotient and
// remainder are written back through HI/LO. While a division is in progress
// the stage requests a pipeline stall.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset (rst = 0 resets)
//   bus   ex_if.slave: decoded operation in, write-back results out
// Parameter:
//   DIV_CYCLES  number of quotient-bit iterations (32 for the 32-bit datapath)
// ---------------------------------------------------------------------------
module ex #(
    parameter int DIV_CYCLES = 32
) (
    input logic clk,
    input logic rst,
    ex_if.slave bus
);

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b110;

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    localparam logic [5:0] LAST_STEP = 6'(DIV_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_ZERO = 2'd1,
        DIV_ON   = 2'd2,
        DIV_END  = 2'd3
    } divState_e;

    divState_e   state_q, state_d;
    logic [5:0]  divCnt_q, divCnt_d;
    logic [63:0] partial_q, partial_d;
    logic [31:0] divisor_q, divisor_d;
    logic        negQuot_q, negQuot_d;
    logic        negRem_q, negRem_d;

    logic [31:0] aluData;
    logic        aluOverflow;
    logic [31:0] sumRes;
    logic [31:0] diffRes;

    logic        isDivClass;
    logic        divStart;
    logic        signedDiv;
    logic [31:0] dividendAbs;
    logic [31:0] divisorAbs;

    logic        stepGe;
    logic [31:0] stepDiff;
    logic [31:0] quotFinal;
    logic [31:0] remFinal;
    logic        divStall;

    // Decode the division request and prepare the operand magnitudes. DIV works
    // on absolute values and fixes the signs at the end; DIVU uses raw operands.
    always_comb begin
        isDivClass  = (bus.alusel_i == SEL_DIV);
        divStart    = isDivClass && ((bus.aluop_i == OP_DIV) || (bus.aluop_i == OP_DIVU));
        signedDiv   = (bus.aluop_i == OP_DIV);
        dividendAbs = (signedDiv && bus.reg1_i[31]) ? (~bus.reg1_i + 32'd1) : bus.reg1_i;
        divisorAbs  = (signedDiv && bus.reg2_i[31]) ? (~bus.reg2_i + 32'd1) : bus.reg2_i;
    end

    // Single-cycle ALU. The result is chosen by the class first and the subtype
    // second; any combination not listed produces zero. Signed overflow only
    // matters for ADD/SUB, where it suppresses the register write.
    always_comb begin
        sumRes      = bus.reg1_i + bus.reg2_i;
        diffRes     = bus.reg1_i - bus.reg2_i;
        aluData     = '0;
        aluOverflow = 1'b0;
        case (bus.alusel_i)
            SEL_NOP: begin
                aluData = '0;
            end
            SEL_LOGIC: begin
                case (bus.aluop_i)
                    OP_OR:   aluData = bus.reg1_i | bus.reg2_i;
                    OP_AND:  aluData = bus.reg1_i & bus.reg2_i;
                    OP_XOR:  aluData = bus.reg1_i ^ bus.reg2_i;
                    OP_NOR:  aluData = ~(bus.reg1_i | bus.reg2_i);
                    default: aluData = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (bus.aluop_i)
                    OP_SLL:  aluData = bus.reg2_i << bus.reg1_i[4:0];
                    OP_SRL:  aluData = bus.reg2_i >> bus.reg1_i[4:0];
                    OP_SRA:  aluData = $signed(bus.reg2_i) >>> bus.reg1_i[4:0];
                    default: aluData = '0;
                endcase
            end
            SEL_ARITH: begin
                case (bus.aluop_i)
                    OP_ADD: begin
                        aluData     = sumRes;
                        aluOverflow = (bus.reg1_i[31] == bus.reg2_i[31]) &&
                                      (sumRes[31] != bus.reg1_i[31]);
                    end
                    OP_ADDU: aluData = sumRes;
                    OP_SUB: begin
                        aluData     = diffRes;
                        aluOverflow = (bus.reg1_i[31] != bus.reg2_i[31]) &&
                                      (diffRes[31] != bus.reg1_i[31]);
                    end
                    OP_SUBU: aluData = diffRes;
                    OP_SLT:  aluData = {31'b0, ($signed(bus.reg1_i) < $signed(bus.reg2_i))};
                    OP_SLTU: aluData = {31'b0, (bus.reg1_i < bus.reg2_i)};
                    default: aluData = '0;
                endcase
            end
            default: begin
                aluData = '0;
            end
        endcase
    end

    // Divider next-state logic. partial_q holds {remainder, quotient/dividend}:
    // each step shifts the pair left by one, trial-subtracts the divisor from
    // the top 33 bits and shifts in a quotient bit of 1 when it fits. Because
    // the remainder is always below the divisor, the 32-bit difference is exact.
    // A flush returns to IDLE and wins over starting a new division.
    always_comb begin
        state_d   = state_q;
        divCnt_d  = divCnt_q;
        partial_d = partial_q;
        divisor_d = divisor_q;
        negQuot_d = negQuot_q;
        negRem_d  = negRem_q;
        divStall  = 1'b0;

        stepGe    = (partial_q[63:31] >= {1'b0, divisor_q});
        stepDiff  = partial_q[62:31] - divisor_q;
        quotFinal = negQuot_q ? (~partial_q[31:0] + 32'd1) : partial_q[31:0];
        remFinal  = negRem_q ? (~partial_q[63:32] + 32'd1) : partial_q[63:32];

        case (state_q)
            IDLE: begin
                divCnt_d = '0;
                if (divStart) begin
                    divStall = 1'b1;
                    if (bus.reg2_i == 32'd0) begin
                        state_d   = DIV_ZERO;
                        partial_d = {bus.reg1_i, 32'hFFFF_FFFF};
                        negQuot_d = 1'b0;
                        negRem_d  = 1'b0;
                    end else begin
                        state_d   = DIV_ON;
                        partial_d = {32'd0, dividendAbs};
                        divisor_d = divisorAbs;
                        negQuot_d = signedDiv && (bus.reg1_i[31] ^ bus.reg2_i[31]);
                        negRem_d  = signedDiv && bus.reg1_i[31];
                    end
                end
            end
            DIV_ZERO: begin
                divStall = 1'b1;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                divStall  = 1'b1;
                partial_d = stepGe ? {stepDiff, partial_q[30:0], 1'b1}
                                   : {partial_q[62:0], 1'b0};
                divCnt_d  = divCnt_q + 6'd1;
                if (divCnt_q == LAST_STEP) begin
                    state_d = DIV_END;
                end
            end
            DIV_END: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.flush_i) begin
            state_d  = IDLE;
            divCnt_d = '0;
        end
    end

    // Divider state register; reset forces IDLE with a cleared counter at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            divCnt_q  <= '0;
            partial_q <= '0;
            divisor_q <= '0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            divCnt_q  <= divCnt_d;
            partial_q <= partial_d;
            divisor_q <= divisor_d;
            negQuot_q <= negQuot_d;
            negRem_q  <= negRem_d;
        end
    end

    // Output drive. Every output is held at zero while reset is asserted, even
    // the purely combinational ones. Divide results appear only in DIV_END.
    always_comb begin
        bus.wd_o       = '0;
        bus.wreg_o     = 1'b0;
        bus.wdata_o    = '0;
        bus.whilo_o    = 1'b0;
        bus.hi_o       = '0;
        bus.lo_o       = '0;
        bus.stallreq_o = 1'b0;
        if (rst) begin
            bus.wd_o       = bus.wd_i;
            bus.wreg_o     = isDivClass ? 1'b0 : (bus.wreg_i && !aluOverflow);
            bus.wdata_o    = isDivClass ? 32'd0 : aluData;
            bus.stallreq_o = divStall;
            if (state_q == DIV_END) begin
                bus.whilo_o = 1'b1;
                bus.hi_o    = remFinal;
                bus.lo_o    = quotFinal;
            end
        end
    end

endmodule

// File: tb/tb_ex.sv
// ---------------------------------------------------------------------------
// tb_ex
// Self-checking bench for the execute stage. A behavioural model computes the
// expected ALU result with wide integer arithmetic and the divide result with
// the language's own division, and tracks divider timing as a countdown of
// stall cycles. A compare process checks every output on every falling edge;
// directed vectors add hand-computed literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ex;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_SHIFT = 3'b010;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_DIV   = 3'b110;

    localparam logic [7:0] OP_OR   = 8'h25;
    localparam logic [7:0] OP_AND  = 8'h24;
    localparam logic [7:0] OP_XOR  = 8'h26;
    localparam logic [7:0] OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C;
    localparam logic [7:0] OP_SRL  = 8'h02;
    localparam logic [7:0] OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20;
    localparam logic [7:0] OP_ADDU = 8'h21;
    localparam logic [7:0] OP_SUB  = 8'h22;
    localparam logic [7:0] OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A;
    localparam logic [7:0] OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_DIV  = 8'h1A;
    localparam logic [7:0] OP_DIVU = 8'h1B;

    logic clk = 1'b0;
    logic rst;

    ex_if exBus ();

    ex #(.DIV_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (exBus)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model divider status: 0 idle, 1 dividing, 2 result cycle.
    int          mdlMode = 0;
    int          mdlLeft = 0;
    logic [31:0] mdlQuot = '0;
    logic [31:0] mdlRem  = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference ALU: wide signed arithmetic decides overflow and comparisons.
    function automatic void aluModel(input logic [2:0] sel, input logic [7:0] op,
                                     input logic [31:0] a, input logic [31:0] b,
                                     input logic wregIn,
                                     output logic [31:0] data, output logic wr);
        longint sa;
        longint sb;
        longint exact;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        exact = 0;
        data  = '0;
        wr    = wregIn;
        if (sel == SEL_LOGIC) begin
            if (op == OP_OR)       data = a | b;
            else if (op == OP_AND) data = a & b;
            else if (op == OP_XOR) data = a ^ b;
            else if (op == OP_NOR) data = ~(a | b);
        end else if (sel == SEL_SHIFT) begin
            if (op == OP_SLL)      data = b << a[4:0];
            else if (op == OP_SRL) data = b >> a[4:0];
            else if (op == OP_SRA) begin
                exact = sb >>> a[4:0];
                data  = exact[31:0];
            end
        end else if (sel == SEL_ARITH) begin
            if (op == OP_ADD || op == OP_ADDU) begin
                exact = sa + sb;
                data  = exact[31:0];
                if (op == OP_ADD && (exact > 64'sd2147483647 || exact < -64'sd2147483648)) wr = 1'b0;
            end else if (op == OP_SUB || op == OP_SUBU) begin
                exact = sa - sb;
                data  = exact[31:0];
                if (op == OP_SUB && (exact > 64'sd2147483647 || exact < -64'sd2147483648)) wr = 1'b0;
            end else if (op == OP_SLT) begin
                data = (sa < sb) ? 32'd1 : 32'd0;
            end else if (op == OP_SLTU) begin
                data = ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
            end
        end else if (sel == SEL_DIV) begin
            wr = 1'b0;
        end
    endfunction

    // Reference divider: truncating division with remainder taking the
    // dividend's sign; division by zero yields all-ones and the raw dividend.
    function automatic void divModel(input logic isSigned, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] q, output logic [31:0] r);
        longint sa;
        longint sb;
        longint qq;
        longint rr;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else begin
            sa = isSigned ? longint'($signed(a)) : longint'({32'd0, a});
            sb = isSigned ? longint'($signed(b)) : longint'({32'd0, b});
            qq = sa / sb;
            rr = sa % sb;
            q  = qq[31:0];
            r  = rr[31:0];
        end
    endfunction

    function automatic logic divPresent();
        return (exBus.alusel_i == SEL_DIV) &&
               ((exBus.aluop_i == OP_DIV) || (exBus.aluop_i == OP_DIVU));
    endfunction

    // Model timing: a non-zero divide stalls 32 cycles after its issue cycle,
    // divide-by-zero stalls 1; then one result cycle, then idle again.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mdlMode = 0;
            mdlLeft = 0;
        end else if (exBus.flush_i) begin
            mdlMode = 0;
        end else begin
            case (mdlMode)
                0: begin
                    if (divPresent()) begin
                        divModel(exBus.aluop_i == OP_DIV, exBus.reg1_i, exBus.reg2_i, mdlQuot, mdlRem);
                        mdlLeft = (exBus.reg2_i == 32'd0) ? 1 : 32;
                        mdlMode = 1;
                    end
                end
                1: begin
                    mdlLeft--;
                    if (mdlLeft == 0) mdlMode = 2;
                end
                default: mdlMode = 0;
            endcase
        end
    end

    // Every falling edge: compare all outputs against the model.
    always @(negedge clk) begin : compare
        logic [31:0] expData;
        logic        expWreg;
        logic [4:0]  expWd;
        logic        expStall;
        logic        expWhilo;
        logic [31:0] expHi;
        logic [31:0] expLo;
        expData  = '0;
        expWreg  = 1'b0;
        expWd    = '0;
        expStall = 1'b0;
        expWhilo = 1'b0;
        expHi    = '0;
        expLo    = '0;
        if (rst) begin
            aluModel(exBus.alusel_i, exBus.aluop_i, exBus.reg1_i, exBus.reg2_i,
                     exBus.wreg_i, expData, expWreg);
            expWd    = exBus.wd_i;
            expStall = (mdlMode == 1) || (mdlMode == 0 && divPresent());
            expWhilo = (mdlMode == 2);
            if (mdlMode == 2) begin
                expHi = mdlRem;
                expLo = mdlQuot;
            end
        end
        checkOutput("cmp wdata", exBus.wdata_o, expData);
        checkOutput("cmp wreg", {31'd0, exBus.wreg_o}, {31'd0, expWreg});
        checkOutput("cmp wd", {27'd0, exBus.wd_o}, {27'd0, expWd});
        checkOutput("cmp stallreq", {31'd0, exBus.stallreq_o}, {31'd0, expStall});
        checkOutput("cmp whilo", {31'd0, exBus.whilo_o}, {31'd0, expWhilo});
        checkOutput("cmp hi", exBus.hi_o, expHi);
        checkOutput("cmp lo", exBus.lo_o, expLo);
    end

    task automatic applyStimulus(input logic [2:0] sel, input logic [7:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] wd, input logic wreg);
        exBus.alusel_i = sel;
        exBus.aluop_i  = op;
        exBus.reg1_i   = a;
        exBus.reg2_i   = b;
        exBus.wd_i     = wd;
        exBus.wreg_i   = wreg;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, " wdata"}, exBus.wdata_o, 32'd0);
        checkOutput({name, " wreg"}, {31'd0, exBus.wreg_o}, 32'd0);
        checkOutput({name, " wd"}, {27'd0, exBus.wd_o}, 32'd0);
        checkOutput({name, " stallreq"}, {31'd0, exBus.stallreq_o}, 32'd0);
        checkOutput({name, " whilo"}, {31'd0, exBus.whilo_o}, 32'd0);
        checkOutput({name, " hi"}, exBus.hi_o, 32'd0);
        checkOutput({name, " lo"}, exBus.lo_o, 32'd0);
    endtask

    task automatic runVector(input string name, input logic [2:0] sel, input logic [7:0] op,
                             input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                             input logic [31:0] expData, input logic expWreg);
        applyStimulus(sel, op, a, b, wd, 1'b1);
        @(negedge clk);
        checkOutput({name, " wdata"}, exBus.wdata_o, expData);
        checkOutput({name, " wreg"}, {31'd0, exBus.wreg_o}, {31'd0, expWreg});
        checkOutput({name, " wd"}, {27'd0, exBus.wd_o}, {27'd0, wd});
        checkOutput({name, " stallreq"}, {31'd0, exBus.stallreq_o}, 32'd0);
        nextCycle();
    endtask

    // Issue a divide, count stall cycles up to the write-back cycle, check it.
    task automatic runDiv(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int expStalls,
                          input logic [31:0] expLo, input logic [31:0] expHi);
        int stalls;
        bit seen;
        stalls = 0;
        seen   = 1'b0;
        applyStimulus(SEL_DIV, op, a, b, 5'd9, 1'b1);
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (exBus.stallreq_o) stalls++;
            if (exBus.whilo_o) begin
                seen = 1'b1;
                checkOutput({name, " lo"}, exBus.lo_o, expLo);
                checkOutput({name, " hi"}, exBus.hi_o, expHi);
            end
        end
        checkOutput({name, " done"}, {31'd0, seen}, 32'd1);
        checkOutput({name, " stalls"}, stalls, expStalls);
        nextCycle();
        applyStimulus(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
    endtask

    task automatic countWhilo(input string name, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (exBus.whilo_o || exBus.stallreq_o) pulses++;
        end
        checkOutput({name, " quiet"}, pulses, 32'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst           = 1'b0;
        exBus.flush_i = 1'b0;
        applyStimulus(SEL_LOGIC, OP_OR, 32'h0000_1100, 32'h0000_0011, 5'd5, 1'b1);
        #3;
        checkAllZero("reset");
        #19;
        rst = 1'b1;
        nextCycle();

        runVector("or",    SEL_LOGIC, OP_OR,   32'h0000_1100, 32'h0000_0011, 5'd5,  32'h0000_1111, 1'b1);
        runVector("and",   SEL_LOGIC, OP_AND,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd6,  32'h00F0_00F0, 1'b1);
        runVector("xor",   SEL_LOGIC, OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd7,  32'hF0F0_0F0F, 1'b1);
        runVector("nor",   SEL_LOGIC, OP_NOR,  32'h0000_FFFF, 32'h00FF_00FF, 5'd8,  32'hFF00_0000, 1'b1);
        runVector("sll",   SEL_SHIFT, OP_SLL,  32'd4,         32'h0000_0001, 5'd9,  32'h0000_0010, 1'b1);
        runVector("srl",   SEL_SHIFT, OP_SRL,  32'd8,         32'h8000_0000, 5'd10, 32'h0080_0000, 1'b1);
        runVector("sra",   SEL_SHIFT, OP_SRA,  32'd4,         32'h8000_0000, 5'd11, 32'hF800_0000, 1'b1);
        runVector("sra5b", SEL_SHIFT, OP_SRA,  32'h0000_0024, 32'h8000_0000, 5'd12, 32'hF800_0000, 1'b1);
        runVector("addov", SEL_ARITH, OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd13, 32'h8000_0000, 1'b0);
        runVector("addu",  SEL_ARITH, OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 5'd14, 32'h8000_0000, 1'b1);
        runVector("add",   SEL_ARITH, OP_ADD,  32'd5,         32'hFFFF_FFFD, 5'd15, 32'h0000_0002, 1'b1);
        runVector("subov", SEL_ARITH, OP_SUB,  32'h8000_0000, 32'h0000_0001, 5'd16, 32'h7FFF_FFFF, 1'b0);
        runVector("subu",  SEL_ARITH, OP_SUBU, 32'h8000_0000, 32'h0000_0001, 5'd17, 32'h7FFF_FFFF, 1'b1);
        runVector("sub",   SEL_ARITH, OP_SUB,  32'd3,         32'd5,         5'd18, 32'hFFFF_FFFE, 1'b1);
        runVector("slt",   SEL_ARITH, OP_SLT,  32'hFFFF_FFFF, 32'd1,         5'd19, 32'h0000_0001, 1'b1);
        runVector("sltu",  SEL_ARITH, OP_SLTU, 32'hFFFF_FFFF, 32'd1,         5'd20, 32'h0000_0000, 1'b1);
        runVector("badsel", 3'b111,   OP_OR,   32'h1234_5678, 32'h1,         5'd21, 32'h0000_0000, 1'b1);
        runVector("badop", SEL_LOGIC, OP_ADD,  32'h1234_5678, 32'h1,         5'd22, 32'h0000_0000, 1'b1);
        runVector("nop",   SEL_NOP,   8'h00,   32'h1234_5678, 32'h1,         5'd23, 32'h0000_0000, 1'b1);

        runDiv("div-7/2",    OP_DIV,  32'hFFFF_FFF9, 32'd2,         33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        runDiv("divu100/7",  OP_DIVU, 32'd100,       32'd7,         33, 32'd14,        32'd2);
        runDiv("divu5/0",    OP_DIVU, 32'd5,         32'd0,         2,  32'hFFFF_FFFF, 32'd5);
        runDiv("divmin/-1",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        runDiv("div7/-2",    OP_DIV,  32'd7,         32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        runDiv("divubig/10", OP_DIVU, 32'hFFFF_FFFF, 32'd10,        33, 32'h1999_9999, 32'd5);
        runDiv("divu5/7",    OP_DIVU, 32'd5,         32'd7,         33, 32'd0,         32'd5);

        applyStimulus(SEL_DIV, OP_DIV, 32'd100, 32'd7, 5'd3, 1'b0);
        repeat (10) nextCycle();
        exBus.flush_i = 1'b1;
        nextCycle();
        exBus.flush_i = 1'b0;
        applyStimulus(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        @(negedge clk);
        checkOutput("flush stallreq", {31'd0, exBus.stallreq_o}, 32'd0);
        checkOutput("flush whilo", {31'd0, exBus.whilo_o}, 32'd0);
        countWhilo("flush", 40);
        nextCycle();
        runDiv("div100/-7", OP_DIV, 32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2);

        applyStimulus(SEL_DIV, OP_DIVU, 32'd1000, 32'd3, 5'd4, 1'b1);
        repeat (20) nextCycle();
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("midreset");
        applyStimulus(SEL_NOP, 8'h00, 32'd0, 32'd0, 5'd0, 1'b0);
        nextCycle();
        nextCycle();
        #2;
        rst = 1'b1;
        countWhilo("postreset", 40);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
